// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: shared types and constants for the VGA AXI-Lite peripheral.
//   native_addr_t / axil_data_t : native word address and register data types
//   csr_addr_e                  : CSR word-address map
//   *_BIT / FRAME_CNT_LSB       : field positions inside CTRL and STATUS
//   bg_color_t                  : RGB444 background colour
package vga_axil_pkg;

    localparam int NATIVE_ADDR_W = 3;
    localparam int AXIL_DATA_W   = 32;
    localparam int FRAME_CNT_W   = 16;

    typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;
    typedef logic [AXIL_DATA_W-1:0]   axil_data_t;

    typedef enum logic [NATIVE_ADDR_W-1:0] {
        CsrCtrl    = 3'd0,
        CsrStatus  = 3'd1,
        CsrBgColor = 3'd2,
        CsrFbBase  = 3'd3,
        CsrScratch = 3'd4,
        CsrId      = 3'd7
    } csr_addr_e;

    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int FRAME_CNT_LSB      = 16;

    typedef logic [11:0] bg_color_t;

endpackage

// File: rtl/vga_edge_detect.sv
// vga_edge_detect: single-flop edge detector for a signal already in clk_i domain.
//   clk_i    : clock
//   arst_n_i : active-low reset, sampled synchronously
//   sig_i    : monitored level
//   pulse_o  : one-cycle pulse when sig_i enters the ACTIVE level
module vga_edge_detect #(
    parameter logic ACTIVE = 1'b1
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic prev_q;

    // Reset loads the inactive level so a signal already active after reset
    // still produces exactly one pulse.
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) prev_q <= ~ACTIVE;
        else           prev_q <= sig_i;
    end

    assign pulse_o = (sig_i == ACTIVE) && (prev_q != ACTIVE);

endmodule

// File: rtl/vga_axil_csr.sv
// vga_axil_csr: VGA control/status register bank behind the AXI-Lite slave FSM.
//   clk_i, arst_n_i           : clock, synchronous active-low reset
//   write_en_i/addr_write_i/data_i : native write channel
//   read_en_i/addr_read_i/data_o   : native read channel (data_o combinational)
//   vsync_i                   : vsync, active level VSYNC_ACTIVE
//   enable_o/bg_color_o/fb_base_o  : frame-boundary shadows of CTRL.enable, BG_COLOR, FB_BASE
//   irq_o                     : level interrupt = pending & irq_en (registered)
// Optional: define VGA_AXIL_CSR_ID_REG_EN to map a read-only ID register at address 7.
module vga_axil_csr
    import vga_axil_pkg::*;
#(
    parameter int                    NATIVE_ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH        = 32,
    parameter logic                  VSYNC_ACTIVE      = 1'b0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE          = 32'h5647_4131
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         write_en_i,
    input  logic [NATIVE_ADDR_WIDTH-1:0] addr_write_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         read_en_i,
    input  logic [NATIVE_ADDR_WIDTH-1:0] addr_read_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         vsync_i,
    output logic                         enable_o,
    output logic [11:0]                  bg_color_o,
    output logic [DATA_WIDTH-1:0]        fb_base_o,
    output logic                         irq_o
);

    logic [1:0]             ctrl_q, ctrl_next;
    bg_color_t              bg_q, bg_next;
    logic [DATA_WIDTH-1:0]  fb_q, fb_next, scratch_q;
    logic                   pending_q, pending_next;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   enable_sh_q, irq_q;
    bg_color_t              bg_sh_q;
    logic [DATA_WIDTH-1:0]  fb_sh_q;
    logic                   vsync_edge;
    logic                   wr_ctrl, wr_status, wr_bg, wr_fb, wr_scratch;

    vga_edge_detect #(.ACTIVE(VSYNC_ACTIVE)) u_vsync_edge (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .sig_i    (vsync_i),
        .pulse_o  (vsync_edge)
    );

    assign wr_ctrl    = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CsrCtrl));
    assign wr_status  = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CsrStatus));
    assign wr_bg      = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CsrBgColor));
    assign wr_fb      = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CsrFbBase));
    assign wr_scratch = write_en_i && (addr_write_i == NATIVE_ADDR_WIDTH'(CsrScratch));

    // Post-write values: shadows, the frame counter enable and irq all see a
    // write landing in the same cycle as the frame edge.
    assign ctrl_next = wr_ctrl ? {data_i[CTRL_IRQ_EN_BIT], data_i[CTRL_ENABLE_BIT]} : ctrl_q;
    assign bg_next   = wr_bg   ? data_i[$bits(bg_color_t)-1:0] : bg_q;
    assign fb_next   = wr_fb   ? data_i : fb_q;

    // A new frame edge beats a simultaneous W1C so no event is lost.
    assign pending_next = vsync_edge ? 1'b1
                        : (wr_status && data_i[STATUS_PENDING_BIT]) ? 1'b0
                        : pending_q;

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            ctrl_q      <= '0;
            bg_q        <= '0;
            fb_q        <= '0;
            scratch_q   <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            enable_sh_q <= 1'b0;
            bg_sh_q     <= '0;
            fb_sh_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_next;
            bg_q      <= bg_next;
            fb_q      <= fb_next;
            pending_q <= pending_next;
            irq_q     <= pending_next & ctrl_next[CTRL_IRQ_EN_BIT];
            if (wr_scratch) scratch_q <= data_i;
            if (vsync_edge) begin
                enable_sh_q <= ctrl_next[CTRL_ENABLE_BIT];
                bg_sh_q     <= bg_next;
                fb_sh_q     <= fb_next;
                if (ctrl_next[CTRL_ENABLE_BIT]) frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_read_i)
            NATIVE_ADDR_WIDTH'(CsrCtrl): begin
                data_o[CTRL_ENABLE_BIT] = ctrl_q[CTRL_ENABLE_BIT];
                data_o[CTRL_IRQ_EN_BIT] = ctrl_q[CTRL_IRQ_EN_BIT];
            end
            NATIVE_ADDR_WIDTH'(CsrStatus): begin
                data_o[STATUS_PENDING_BIT]               = pending_q;
                data_o[FRAME_CNT_LSB +: FRAME_CNT_W]     = frame_cnt_q;
            end
            NATIVE_ADDR_WIDTH'(CsrBgColor): data_o[$bits(bg_color_t)-1:0] = bg_q;
            NATIVE_ADDR_WIDTH'(CsrFbBase):  data_o = fb_q;
            NATIVE_ADDR_WIDTH'(CsrScratch): data_o = scratch_q;
`ifdef VGA_AXIL_CSR_ID_REG_EN
            NATIVE_ADDR_WIDTH'(CsrId):      data_o = ID_VALUE;
`endif
            default:                        data_o = '0;
        endcase
    end

    // Reads are side-effect free, so read_en_i carries no information here.
`ifdef VGA_AXIL_CSR_ID_REG_EN
    logic unused_inputs;
    assign unused_inputs = read_en_i;
`else
    logic unused_inputs;
    assign unused_inputs = ^{read_en_i, ID_VALUE};
`endif

    assign enable_o   = enable_sh_q;
    assign bg_color_o = bg_sh_q;
    assign fb_base_o  = fb_sh_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_vga_axil_csr.sv
module tb_vga_axil_csr;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        write_en;
    logic [2:0]  addr_write;
    logic [31:0] data_w;
    logic        read_en;
    logic [2:0]  addr_read;
    logic [31:0] data_r;
    logic        vsync;
    logic        enable;
    logic [11:0] bg_color;
    logic [31:0] fb_base;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_axil_csr dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .write_en_i   (write_en),
        .addr_write_i (addr_write),
        .data_i       (data_w),
        .read_en_i    (read_en),
        .addr_read_i  (addr_read),
        .data_o       (data_r),
        .vsync_i      (vsync),
        .enable_o     (enable),
        .bg_color_o   (bg_color),
        .fb_base_o    (fb_base),
        .irq_o        (irq)
    );

`ifdef VGA_AXIL_CSR_ID_REG_EN
    localparam logic [31:0] EXP_ADDR7 = 32'h5647_4131;
`else
    localparam logic [31:0] EXP_ADDR7 = 32'h0;
`endif

    // Behavioural model: register file plus frame-event bookkeeping.
    bit [1:0]  m_ctrl;
    bit [11:0] m_bg, m_bgs;
    bit [31:0] m_fb, m_fbs, m_scr;
    bit        m_pend, m_en, m_irq, m_prev;
    bit [15:0] m_cnt;

    function automatic bit [31:0] model_read(input bit [2:0] a);
        case (a)
            3'd0: return {30'b0, m_ctrl};
            3'd1: return {m_cnt, 15'b0, m_pend};
            3'd2: return {20'b0, m_bg};
            3'd3: return m_fb;
            3'd4: return m_scr;
            3'd7: return EXP_ADDR7;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clock(input bit rst_n, input bit we, input bit [2:0] wa,
                               input bit [31:0] wd, input bit vs);
        bit frame, clr;
        if (!rst_n) begin
            m_ctrl = 0; m_bg = 0; m_bgs = 0; m_fb = 0; m_fbs = 0; m_scr = 0;
            m_pend = 0; m_en = 0; m_irq = 0; m_cnt = 0; m_prev = 1'b1;
            return;
        end
        frame  = (vs == 1'b0) && m_prev;
        m_prev = vs;
        clr    = 1'b0;
        if (we) begin
            case (wa)
                3'd0: m_ctrl = wd[1:0];
                3'd1: clr    = wd[0];
                3'd2: m_bg   = wd[11:0];
                3'd3: m_fb   = wd;
                3'd4: m_scr  = wd;
                default: ;
            endcase
        end
        if (frame) begin
            m_en  = m_ctrl[0];
            m_bgs = m_bg;
            m_fbs = m_fb;
            if (m_ctrl[0]) m_cnt = m_cnt + 16'd1;
            m_pend = 1'b1;
        end else if (clr) begin
            m_pend = 1'b0;
        end
        m_irq = m_pend & m_ctrl[1];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] last_rd;

    // One clock of stimulus: data_o checked before the edge, outputs after it.
    task automatic step(input bit rst_n, input bit we, input bit [2:0] wa,
                        input bit [31:0] wd, input bit vs, input bit [2:0] ra);
        @(negedge clk);
        arst_n = rst_n; write_en = we; addr_write = wa; data_w = wd;
        vsync = vs; addr_read = ra; read_en = 1'b1;
        #1;
        last_rd = data_r;
        if (rst_n) chk("rd_model", data_r, model_read(ra));
        @(posedge clk);
        model_clock(rst_n, we, wa, wd, vs);
        #1;
        chk("enable_model", {31'b0, enable}, {31'b0, m_en});
        chk("bg_model", {20'b0, bg_color}, {20'b0, m_bgs});
        chk("fb_model", fb_base, m_fbs);
        chk("irq_model", {31'b0, irq}, {31'b0, m_irq});
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  wa;
        bit [31:0] wd;
        bit        vs;
        bit [2:0]  ra;
        bit [31:0] exp_rd;
        bit        exp_en;
        bit [11:0] exp_bg;
        bit [31:0] exp_fb;
        bit        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit we, bit [2:0] wa, bit [31:0] wd, bit vs, bit [2:0] ra,
                                bit [31:0] rd, bit en, bit [11:0] bg, bit [31:0] fb, bit iq);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.vs = vs; v.ra = ra;
        v.exp_rd = rd; v.exp_en = en; v.exp_bg = bg; v.exp_fb = fb; v.exp_irq = iq;
        tbl.push_back(v);
    endfunction

    initial begin
        arst_n = 1'b0; write_en = 1'b0; addr_write = '0; data_w = '0;
        read_en = 1'b0; addr_read = '0; vsync = 1'b1;

        // Reset state: every address reads 0 (or ID), shadows and irq low.
        for (int a = 0; a < 7; a++) add(0, 0, 0, 1, 3'(a), 32'h0, 0, 12'h0, 32'h0, 0);
        add(0, 0, 0, 1, 3'd7, EXP_ADDR7, 0, 12'h0, 32'h0, 0);
        // Configuration writes do not reach the shadows until a frame edge.
        add(1, 3, 32'h0001_2000, 1, 3, 32'h0,         0, 12'h0,   32'h0,         0);
        add(1, 2, 32'hFFFF_FABC, 1, 3, 32'h0001_2000, 0, 12'h0,   32'h0,         0);
        add(1, 0, 32'h0000_0001, 1, 2, 32'h0000_0ABC, 0, 12'h0,   32'h0,         0);
        add(0, 0, 0,             1, 0, 32'h0000_0001, 0, 12'h0,   32'h0,         0);
        add(0, 0, 0,             0, 1, 32'h0,         1, 12'hABC, 32'h0001_2000, 0);
        add(0, 0, 0,             1, 1, 32'h0001_0001, 1, 12'hABC, 32'h0001_2000, 0);
        // Clear pending, enable irq, then two more frames.
        add(1, 1, 32'h1,         1, 1, 32'h0001_0001, 1, 12'hABC, 32'h0001_2000, 0);
        add(1, 0, 32'h3,         1, 1, 32'h0001_0000, 1, 12'hABC, 32'h0001_2000, 0);
        add(0, 0, 0,             0, 0, 32'h0000_0003, 1, 12'hABC, 32'h0001_2000, 1);
        add(0, 0, 0,             1, 1, 32'h0002_0001, 1, 12'hABC, 32'h0001_2000, 1);
        add(0, 0, 0,             0, 1, 32'h0002_0001, 1, 12'hABC, 32'h0001_2000, 1);
        add(0, 0, 0,             1, 1, 32'h0003_0001, 1, 12'hABC, 32'h0001_2000, 1);
        add(1, 1, 32'h1,         1, 1, 32'h0003_0001, 1, 12'hABC, 32'h0001_2000, 0);
        add(0, 0, 0,             1, 1, 32'h0003_0000, 1, 12'hABC, 32'h0001_2000, 0);
        // W1C coinciding with a frame edge: set wins.
        add(1, 1, 32'h1,         0, 1, 32'h0003_0000, 1, 12'hABC, 32'h0001_2000, 1);
        add(0, 0, 0,             1, 1, 32'h0004_0001, 1, 12'hABC, 32'h0001_2000, 1);

        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_enable", {31'b0, enable}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].vs, tbl[i].ra);
            chk($sformatf("vec%0d_rd", i), last_rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_en", i), {31'b0, enable}, {31'b0, tbl[i].exp_en});
            chk($sformatf("vec%0d_bg", i), {20'b0, bg_color}, {20'b0, tbl[i].exp_bg});
            chk($sformatf("vec%0d_fb", i), fb_base, tbl[i].exp_fb);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
        end

        // Frame counter wrap: preload 0xFFFF, one enabled frame returns it to 0.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        step(0 == 1 ? 0 : 1, 0, 0, 0, 1, 1);
        chk("wrap_pre", last_rd, 32'hFFFF_0001);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        chk("wrap_post", last_rd, 32'h0000_0001);
        // Disabled frames do not count but still set pending.
        step(1, 1, 0, 32'h0, 1, 1);
        step(1, 1, 1, 32'h1, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        chk("dis_cleared", last_rd, 32'h0000_0000);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        chk("dis_pending", last_rd, 32'h0000_0001);
        chk("dis_enable", {31'b0, enable}, 32'h0);
        chk("dis_irq", {31'b0, irq}, 32'h0);

        // Mid-frame reset wipes SCRATCH, shadows, counter and irq.
        step(1, 1, 0, 32'h3, 1, 0);
        step(1, 1, 4, 32'hDEAD_BEEF, 0, 4);
        step(1, 0, 0, 0, 1, 4);
        chk("scratch_set", last_rd, 32'hDEAD_BEEF);
        step(0, 1, 3, 32'hFFFF_FFFF, 0, 4);
        step(1, 0, 0, 0, 1, 4);
        chk("rst_scratch", last_rd, 32'h0);
        chk("rst_fb", fb_base, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        step(1, 0, 0, 0, 1, 1);
        chk("rst_status", last_rd, 32'h0);
        step(1, 0, 0, 0, 1, 7);
        chk("addr7", last_rd, EXP_ADDR7);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bit rn, we, vs;
            bit [2:0] wa, ra;
            bit [31:0] wd;
            rn = ($urandom_range(0, 63) != 0);
            we = $urandom_range(0, 1);
            wa = 3'($urandom_range(0, 7));
            wd = $urandom;
            ra = 3'($urandom_range(0, 7));
            vs = ($urandom_range(0, 3) == 0) ? ~vsync : vsync;
            step(rn, we, wa, wd, vs, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_axil_csr.md
Name: vga_axil_csr

Overview:
- Control/status register bank directly downstream of the AXI-Lite slave FSM.
- Consumes its native write/read strobes, addresses and write data. Returns read data on data_o, which feeds the FSM's data_i.
- Holds VGA timing-engine configuration in shadow registers, updated only at frame boundaries.
- Counts frames and raises a vsync interrupt.

Parameters:
- NATIVE_ADDR_WIDTH, 3, width of word address (vga_axil_pkg::native_addr_t width)
- DATA_WIDTH, 32, register width (vga_axil_pkg::axil_data_t width)
- VSYNC_ACTIVE, 1'b0, active level of vsync_i
- ID_VALUE, 32'h5647_4131, constant returned by ID register (optional feature)

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  active-low reset, sampled synchronously on clk_i
- write_en_i  in  1  one-cycle write strobe from slave FSM
- addr_write_i  in  NATIVE_ADDR_WIDTH  word address of write
- data_i  in  DATA_WIDTH  write data
- read_en_i  in  1  one-cycle read strobe from slave FSM
- addr_read_i  in  NATIVE_ADDR_WIDTH  word address of read
- data_o  out  DATA_WIDTH  read data to slave FSM data_i
- vsync_i  in  1  vsync from timing generator, already in clk_i domain
- enable_o  out  1  shadowed CTRL.enable
- bg_color_o  out  12  shadowed BG_COLOR (RGB444)
- fb_base_o  out  DATA_WIDTH  shadowed FB_BASE
- irq_o  out  1  interrupt, level

Behaviour:
- Reset: synchronous, active-low; arst_n_i low at a clk_i edge takes priority over all other activity, including mid-transaction.
  - All registers, shadows, counters, pending flag and irq_o go to 0.
  - Edge-detect flop loads the inactive vsync level.
- Register map (word addresses):
  - 0 CTRL: RW; [0] enable, [1] irq_en.
  - 1 STATUS: [0] vsync_pending, W1C; [31:16] frame_cnt, RO; other bits read 0.
  - 2 BG_COLOR: RW [11:0].
  - 3 FB_BASE: RW, full width.
  - 4 SCRATCH: RW, full width.
  - 5..7: reserved. Reads return 0; writes are ignored.
- Writes: when write_en_i=1, the addressed register updates at that clk_i edge; unused bits are discarded.
- Reads: data_o is purely combinational from addr_read_i and current register state, with zero latency. The FSM samples it in the cycle read_en_i is high. read_en_i has no side effects.
- Simultaneous read and write (separate FSM channels) are both serviced. A same-address read returns the pre-write value.
- Frame edge: vsync_i synchronous to clk_i. vsync_edge = vsync_i at active level AND previous sample inactive. Single flop, one-cycle pulse.
- On vsync_edge:
  - enable_o, bg_color_o, fb_base_o load from CTRL.enable, BG_COLOR and FB_BASE.
  - If CTRL.enable=1, frame_cnt increments (16-bit, wraps 0xFFFF->0x0000).
  - vsync_pending sets regardless of enable.
- Write plus edge in the same cycle:
  - Shadow loads the value being written (write-through priority).
  - W1C clear plus edge in the same cycle: set wins; pending stays 1.
- irq_o: registered, irq_o <= vsync_pending_next & irq_en_next. Asserts one cycle after the pending set; deasserts one cycle after the clear or after irq_en goes 0.
- Outputs change only on clk_i edges; data_o is the only combinational output.

Optional Feature:
- Macro: VGA_AXIL_CSR_ID_REG_EN.
- Defined: address 7 is a read-only ID register returning ID_VALUE; writes ignored.
- Undefined: address 7 is reserved (reads 0); ID_VALUE is unused.

Decomposition:
- vga_axil_pkg gains:
  - csr_addr_e enum: CsrCtrl=0, CsrStatus=1, CsrBgColor=2, CsrFbBase=3, CsrScratch=4, CsrId=7.
  - Bit-index constants CTRL_ENABLE_BIT, CTRL_IRQ_EN_BIT, STATUS_PENDING_BIT, FRAME_CNT_LSB.
  - bg_color_t (logic [11:0]).
- One sub-module, vga_edge_detect: param ACTIVE, ports clk_i, arst_n_i, sig_i, pulse_o. Reused later for hsync.

Test Plan:
1. Reset, then read addresses 0..7 -> all return 0 (0..6, and 7 without the macro); irq_o=0; shadow outputs 0.
2. Write FB_BASE=0x0001_2000, BG_COLOR=0xABC, CTRL=0x1 -> read-back returns the same values; fb_base_o, bg_color_o and enable_o stay 0 until the next vsync_edge, then show 0x0001_2000, 0xABC, 1.
3. CTRL=0x3; pulse vsync 3 times -> STATUS reads 0x0003_0001; irq_o high one cycle after the first edge. Write STATUS=0x1 -> STATUS reads 0x0003_0000; irq_o low next cycle.
4. W1C to STATUS in the same cycle as a vsync_edge -> pending remains 1 and irq_o stays high.
5. Preload frame_cnt to 0xFFFF via 65535 edges (or force) -> next edge gives frame_cnt 0x0000. With CTRL.enable=0, edges do not increment but pending still sets.
6. Write SCRATCH=0xDEADBEEF, then assert arst_n_i=0 for one cycle mid-frame -> SCRATCH reads 0; shadows, irq_o and frame_cnt are 0. With VGA_AXIL_CSR_ID_REG_EN defined, read of address 7 returns 0x5647_4131.
